// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator.
// The state encoding is fixed at 2 bits so that waveforms decode the same way in every build.
package product_acc_pkg;

   localparam int PROD_W      = 8;
   localparam int DEF_ACC_W   = 16;
   localparam int DEF_MAX_LEN = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-beat input handshake and held-result output handshake.
// slave = accumulator side, master = producer/sink side.
interface product_accumulator_if #(
   parameter int ACC_W = product_acc_pkg::DEF_ACC_W,
   parameter int CNT_W = $clog2(product_acc_pkg::DEF_MAX_LEN + 1)
);
   logic                              in_valid;
   logic                              in_ready;
   logic [product_acc_pkg::PROD_W-1:0] in_data;
   logic                              in_last;
   logic                              out_valid;
   logic                              out_ready;
   logic [ACC_W-1:0]                  out_data;
   logic [CNT_W-1:0]                  out_count;
   logic                              out_ovf;
   logic                              out_trunc;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf, out_trunc
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf, out_trunc
   );
endinterface

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: acc + zero-extended product, carry out of ACC_W.
// Saturating clamp is built only when PRODUCT_ACC_SATURATE_EN is defined; otherwise the sum wraps.
module acc_add_sat import product_acc_pkg::*; #(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_addend,
   input  logic              i_sat_mode,
   output logic [ACC_W-1:0]  o_acc,
   output logic              o_carry
);
   logic [ACC_W:0] w_sum;

   assign w_sum   = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_addend};
   assign o_carry = w_sum[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, any further non-zero add carries again, so the clamp holds for the frame.
   assign o_acc = (i_sat_mode && w_sum[ACC_W]) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   logic w_unused_sat;
   assign w_unused_sat = i_sat_mode;
   assign o_acc        = w_sum[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a frame of 8-bit products into an ACC_W sum; result held in DONE until the sink takes it.
// Optional build macro: PRODUCT_ACC_SATURATE_EN (clamp instead of wrap on overflow).
module product_accumulator import product_acc_pkg::*; #(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic                 clk,
   input  logic                 rst,
   product_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   state_t           r_state, w_state_nxt;
   logic [ACC_W-1:0] r_acc, w_acc_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic             r_trunc, w_trunc_nxt;
   logic             r_in_ready;

   logic             w_xfer;
   logic [ACC_W-1:0] w_add_acc;
   logic             w_add_carry;
   logic [CNT_W-1:0] w_count_inc;

   assign w_xfer      = bus.in_valid & r_in_ready;
   assign w_count_inc = r_count + CNT_W'(1);

   acc_add_sat #(.ACC_W(ACC_W)) u_add (
      .i_acc      (r_acc),
      .i_addend   (bus.in_data),
      .i_sat_mode (1'b1),
      .o_acc      (w_add_acc),
      .o_carry    (w_add_carry)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count;
      w_ovf_nxt   = r_ovf;
      w_trunc_nxt = r_trunc;
      case (r_state)
         ST_IDLE: begin
            // acc is zero here, so the adder output equals in_data.
            if (w_xfer) begin
               w_acc_nxt   = w_add_acc;
               w_count_nxt = CNT_W'(1);
               w_ovf_nxt   = w_add_carry;
               if (bus.in_last || (MAX_LEN == 1)) begin
                  w_state_nxt = ST_DONE;
                  w_trunc_nxt = (MAX_LEN == 1) && !bus.in_last;
               end else begin
                  w_state_nxt = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            if (w_xfer) begin
               w_acc_nxt   = w_add_acc;
               w_count_nxt = w_count_inc;
               w_ovf_nxt   = r_ovf | w_add_carry;
               if (bus.in_last) begin
                  w_state_nxt = ST_DONE;
               end else if (w_count_inc == CNT_W'(MAX_LEN)) begin
                  w_state_nxt = ST_DONE;
                  w_trunc_nxt = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
               w_acc_nxt   = '0;
               w_count_nxt = '0;
               w_ovf_nxt   = 1'b0;
               w_trunc_nxt = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // in_ready is registered so it stays low for the first cycle after reset releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_acc      <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_trunc    <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_count    <= w_count_nxt;
         r_ovf      <= w_ovf_nxt;
         r_trunc    <= w_trunc_nxt;
         r_in_ready <= (w_state_nxt != ST_DONE);
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_data  = r_acc;
   assign bus.out_count = r_count;
   assign bus.out_ovf   = r_ovf;
   assign bus.out_trunc = r_trunc;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed table of frames plus hand-written truncation, backpressure and reset sequences.
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
module tb_product_accumulator;
   localparam int ACC_W   = 10;
   localparam int MAX_LEN = 16;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   product_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   product_accumulator #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int beats;
      int val;
      int exp_data;
      int exp_cnt;
      int exp_ovf;
      int exp_trunc;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic send_beat(input int d, input logic l);
      int waited;
      waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(d);
      bus.in_last  = l;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout actual=0 expected=1");
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("drain_valid", bus.out_valid, 0);
      check("drain_data", bus.out_data, 0);
      check("drain_count", bus.out_count, 0);
      check("drain_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef PRODUCT_ACC_SATURATE_EN
      vecs[0] = '{4, 225, 900, 4, 0, 0};
      vecs[1] = '{1, 42, 42, 1, 0, 0};
      vecs[2] = '{5, 255, 1023, 5, 1, 0};
      vecs[3] = '{16, 1, 16, 16, 0, 0};
      vecs[4] = '{3, 0, 0, 3, 0, 0};
      vecs[5] = '{6, 200, 1023, 6, 1, 0};
`else
      vecs[0] = '{4, 225, 900, 4, 0, 0};
      vecs[1] = '{1, 42, 42, 1, 0, 0};
      vecs[2] = '{5, 255, 251, 5, 1, 0};
      vecs[3] = '{16, 1, 16, 16, 0, 0};
      vecs[4] = '{3, 0, 0, 3, 0, 0};
      vecs[5] = '{6, 200, 176, 6, 1, 0};
`endif

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_count", bus.out_count, 0);
      check("rst_out_ovf", bus.out_ovf, 0);
      check("rst_out_trunc", bus.out_trunc, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);

      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < vecs[i].beats; b++)
            send_beat(vecs[i].val, b == vecs[i].beats - 1);
         check($sformatf("v%0d_valid", i), bus.out_valid, 1);
         check($sformatf("v%0d_in_ready", i), bus.in_ready, 0);
         check($sformatf("v%0d_data", i), bus.out_data, vecs[i].exp_data);
         check($sformatf("v%0d_count", i), bus.out_count, vecs[i].exp_cnt);
         check($sformatf("v%0d_ovf", i), bus.out_ovf, vecs[i].exp_ovf);
         check($sformatf("v%0d_trunc", i), bus.out_trunc, vecs[i].exp_trunc);
         drain();
      end

      // Truncation at MAX_LEN, then a pending beat held off by backpressure.
      for (int b = 0; b < MAX_LEN; b++)
         send_beat(1, 1'b0);
      check("trunc_valid", bus.out_valid, 1);
      check("trunc_data", bus.out_data, 16);
      check("trunc_count", bus.out_count, 16);
      check("trunc_flag", bus.out_trunc, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd5;
      bus.in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp%0d_in_ready", c), bus.in_ready, 0);
         check($sformatf("bp%0d_valid", c), bus.out_valid, 1);
         check($sformatf("bp%0d_data", c), bus.out_data, 16);
         check($sformatf("bp%0d_count", c), bus.out_count, 16);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_drain_valid", bus.out_valid, 0);
      check("bp_drain_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check("bp_next_valid", bus.out_valid, 1);
      check("bp_next_data", bus.out_data, 5);
      check("bp_next_count", bus.out_count, 1);
      check("bp_next_trunc", bus.out_trunc, 0);
      drain();

      // Reset in the middle of a frame.
      for (int b = 0; b < 3; b++)
         send_beat(10, 1'b0);
      check("mid_acc", bus.out_data, 30);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data", bus.out_data, 0);
      check("mid_rst_count", bus.out_count, 0);
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      check("mid_rst_ready_back", bus.in_ready, 1);
      send_beat(7, 1'b0);
      send_beat(7, 1'b1);
      check("after_rst_valid", bus.out_valid, 1);
      check("after_rst_data", bus.out_data, 14);
      check("after_rst_count", bus.out_count, 2);
      check("after_rst_ovf", bus.out_ovf, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
